// File: rtl/prog_mem.sv
// prog_mem: loadable program memory with a registered single-cycle fetch port
module prog_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              hold,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fault,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              busy,
    output logic              ld_ovf
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic {RUN, LOAD} state_t;
    state_t state_q, state_d;
    logic [ADDR_W:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic instr_valid_q, instr_valid_d, fault_q, fault_d, ld_ovf_q, ld_ovf_d;
    logic we, addr_ok, ptr_full;
    logic [DATA_W-1:0] mem [DEPTH];
    assign addr_ok  = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
    assign ptr_full = ptr_q == (ADDR_W+1)'(DEPTH);
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        ld_ovf_d      = ld_ovf_q;
        we            = 1'b0;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        if (ld_start) begin
            state_d  = LOAD;
            ptr_d    = '0;
            ld_ovf_d = 1'b0;
        end else if (state_q == LOAD && ld_valid) begin
            ld_ovf_d = ld_ovf_q | ptr_full;
            we       = ~ptr_full;
            ptr_d    = ptr_full ? ptr_q : ptr_q + 1'b1;
            state_d  = (ptr_full || ld_last) ? RUN : LOAD;
        end
        // loading owns the memory; fetches are dropped rather than stalled
        if (ld_start || state_q == LOAD) begin
            instr_valid_d = 1'b0;
        end else if (!hold) begin
            instr_valid_d = fetch_req;
            instr_d       = fetch_req ? (addr_ok ? mem[addr[IW-1:0]] : '0) : instr_q;
            fault_d       = fault_q | (fetch_req & ~addr_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            ptr_q         <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            ld_ovf_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            ld_ovf_q      <= ld_ovf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n && we) mem[ptr_q[IW-1:0]] <= ld_data;
    end
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;
    assign busy        = state_q == LOAD;
    assign ld_ovf      = ld_ovf_q;
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: two prog_mem instances (DEPTH 12 and 4) on shared stimulus, checked against a rule model
module tb_prog_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fetch_req = 1'b0, hold = 1'b0, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [7:0] addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] instr [2];
    logic instr_valid [2], fault [2], busy [2], ld_ovf [2];
    int cmp_n = 0, bad_n = 0;
    int dep [2] = '{12, 4};
    logic [15:0] mm [2][256];
    bit mk [2][256];
    bit m_load [2], m_known [2], m_iv [2], m_fault [2], m_ovf [2];
    int m_ptr [2];
    logic [15:0] m_instr [2];

    always #5 clk = ~clk;

    prog_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(12)) dut_a (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .addr(addr), .hold(hold),
        .instr(instr[0]), .instr_valid(instr_valid[0]), .fault(fault[0]),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .busy(busy[0]), .ld_ovf(ld_ovf[0]));
    prog_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .addr(addr), .hold(hold),
        .instr(instr[1]), .instr_valid(instr_valid[1]), .fault(fault[1]),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .busy(busy[1]), .ld_ovf(ld_ovf[1]));

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_load[i] = 0; m_ptr[i] = 0; m_iv[i] = 0; m_instr[i] = '0;
                m_known[i] = 1; m_fault[i] = 0; m_ovf[i] = 0;
            end else begin
                if (ld_start || m_load[i]) m_iv[i] = 0;
                else if (!hold) begin
                    m_iv[i] = fetch_req;
                    if (fetch_req && int'(addr) >= dep[i]) begin
                        m_instr[i] = '0; m_known[i] = 1; m_fault[i] = 1;
                    end else if (fetch_req) begin
                        m_instr[i] = mm[i][addr]; m_known[i] = mk[i][addr];
                    end
                end
                if (ld_start) begin
                    m_load[i] = 1; m_ptr[i] = 0; m_ovf[i] = 0;
                end else if (m_load[i] && ld_valid) begin
                    if (m_ptr[i] == dep[i]) begin
                        m_ovf[i] = 1; m_load[i] = 0;
                    end else begin
                        mm[i][m_ptr[i]] = ld_data; mk[i][m_ptr[i]] = 1;
                        m_ptr[i]++;
                        if (ld_last) m_load[i] = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check("instr_valid", i, 32'(instr_valid[i]), 32'(m_iv[i]));
            check("busy", i, 32'(busy[i]), 32'(m_load[i]));
            check("fault", i, 32'(fault[i]), 32'(m_fault[i]));
            check("ld_ovf", i, 32'(ld_ovf[i]), 32'(m_ovf[i]));
            if (m_known[i]) check("instr", i, 32'(instr[i]), 32'(m_instr[i]));
        end
    endtask

    task automatic drive(input bit fr, input int a, input bit h, input bit ls,
                         input bit lv, input int d, input bit ll);
        fetch_req = fr; addr = 8'(a); hold = h; ld_start = ls;
        ld_valid = lv; ld_data = 16'(d); ld_last = ll;
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 16'hDEAD, 0);
        check("rst_valid", 0, 32'(instr_valid[0]), 0);
        check("rst_instr", 0, 32'(instr[0]), 0);
        rst_n = 1;
        // load three words; start collides with a fetch and fetches keep coming during load
        drive(1, 0, 0, 1, 0, 0, 0);
        check("conflict_busy", 0, 32'(busy[0]), 1);
        check("conflict_valid", 0, 32'(instr_valid[0]), 0);
        drive(1, 1, 0, 0, 1, 16'h0012, 0);
        drive(1, 2, 0, 0, 1, 16'h0043, 0);
        drive(1, 0, 0, 0, 1, 16'h0067, 1);
        check("load_fetch_valid", 0, 32'(instr_valid[0]), 0);
        check("load_end_busy", 0, 32'(busy[0]), 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("fetch0", 0, 32'(instr[0]), 32'h0012);
        drive(1, 1, 0, 0, 0, 0, 0);
        check("fetch1", 0, 32'(instr[0]), 32'h0043);
        drive(1, 2, 0, 0, 0, 0, 0);
        check("fetch2", 0, 32'(instr[0]), 32'h0067);
        check("fetch2_valid", 0, 32'(instr_valid[0]), 1);
        drive(0, 2, 0, 0, 0, 0, 0);
        check("idle_valid", 0, 32'(instr_valid[0]), 0);
        check("idle_instr", 0, 32'(instr[0]), 32'h0067);
        // stall
        drive(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 2, 1, 0, 0, 0, 0);
            check("hold_instr", 0, 32'(instr[0]), 32'h0043);
            check("hold_valid", 0, 32'(instr_valid[0]), 1);
        end
        drive(1, 2, 0, 0, 0, 0, 0);
        check("after_hold", 0, 32'(instr[0]), 32'h0067);
        // out of range
        drive(1, 12, 0, 0, 0, 0, 0);
        check("oor_instr", 0, 32'(instr[0]), 0);
        check("oor_fault", 0, 32'(fault[0]), 1);
        for (int k = 0; k < 10; k++) drive(1, k % 3, 0, 0, 0, 0, 0);
        check("fault_sticky", 0, 32'(fault[0]), 1);
        // overflow on the 4-deep instance; 12-deep keeps loading
        drive(1, 0, 0, 1, 0, 0, 0);
        check("restart_valid", 0, 32'(instr_valid[0]), 0);
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 1, 16'h0100 + k, 0);
        check("ovf_b", 1, 32'(ld_ovf[1]), 1);
        check("ovf_busy_b", 1, 32'(busy[1]), 0);
        check("nofull_busy_a", 0, 32'(busy[0]), 1);
        check("nofull_ovf_a", 0, 32'(ld_ovf[0]), 0);
        drive(0, 0, 0, 0, 1, 16'h0105, 1);
        for (int k = 0; k < 6; k++) drive(1, k, 0, 0, 0, 0, 0);
        check("ovf_word5_a", 0, 32'(instr[0]), 32'h0105);
        drive(1, 3, 0, 0, 0, 0, 0);
        check("ovf_word3_b", 1, 32'(instr[1]), 32'h0103);
        // reset mid-load, with a write presented during the reset cycle
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 16'h00A1, 0);
        drive(0, 0, 0, 0, 1, 16'h00B2, 0);
        rst_n = 0;
        drive(1, 2, 0, 0, 1, 16'h00C3, 0);
        check("rst_busy", 0, 32'(busy[0]), 0);
        check("rst_valid2", 0, 32'(instr_valid[0]), 0);
        check("rst_fault", 0, 32'(fault[0]), 0);
        rst_n = 1;
        drive(1, 1, 0, 0, 0, 0, 0);
        check("rst_word1", 0, 32'(instr[0]), 32'h00B2);
        drive(1, 2, 0, 0, 0, 0, 0);
        check("rst_word2_kept", 0, 32'(instr[0]), 32'h0102);
        drive(0, 0, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end
endmodule
